// File: rtl/uart_byte_fifo.sv
// Byte FIFO between the UART receiver and transmitter; a small read FSM
// pops one byte at a time and paces it on the transmitter's busy flag.
//
// state   | meaning
// IDLE    | wait for a stored byte and an idle transmitter
// LOAD    | pop the oldest byte into tx_data
// START   | tx_start high for this one cycle
// WAIT_HI | wait for tx_busy to rise; give up after 4 cycles
// WAIT_LO | wait for the frame to finish
module uart_byte_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  input  logic              clear,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
  output logic [AW:0]       count,
  output logic              empty,
  output logic              full,
  output logic              overflow
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT_HI,
    ST_WAIT_LO
  } state_t;

  logic [DATA_W-1:0] mem_q [DEPTH];

  state_t            state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              ovf_q, ovf_d;
  logic [1:0]        timer_q, timer_d;
  logic              tx_start_q, tx_start_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              wr_en, pop;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    timer_d    = timer_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    pop        = 1'b0;
    wr_en      = 1'b0;

    // tx_start is registered on the way out of LOAD so it is high during START
    case (state_q)
      ST_IDLE: begin
        if ((count_q != '0) && !tx_busy) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        pop        = 1'b1;
        tx_data_d  = mem_q[rd_ptr_q];
        rd_ptr_d   = rd_ptr_q + 1'b1;
        tx_start_d = 1'b1;
        state_d    = ST_START;
      end
      ST_START: begin
        timer_d = 2'd3;
        state_d = ST_WAIT_HI;
      end
      ST_WAIT_HI: begin
        if (tx_busy)               state_d = ST_WAIT_LO;
        else if (timer_q == 2'd0)  state_d = ST_IDLE;
        else                       timer_d = timer_q - 2'd1;
      end
      ST_WAIT_LO: begin
        if (!tx_busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // a pop in the same cycle frees the slot a full FIFO would otherwise refuse
    wr_en = rx_valid && ((count_q != DEPTH_C) || pop);
    if (rx_valid && !wr_en) ovf_d = 1'b1;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;

    case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (clear) begin
      wr_en      = 1'b0;
      pop        = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      ovf_d      = 1'b0;
      timer_d    = 2'd0;
      tx_start_d = 1'b0;
      tx_data_d  = tx_data_q;
      state_d    = ST_IDLE;
    end
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      timer_q    <= 2'd0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      timer_q    <= timer_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

  // storage needs no reset; contents are only read behind a valid count
  always_ff @(posedge sys_clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= rx_data;
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign count    = count_q;
  assign empty    = (count_q == '0);
  assign full     = (count_q == DEPTH_C);
  assign overflow = ovf_q;

endmodule

// File: tb/tb_uart_byte_fifo.sv
// Bench for uart_byte_fifo: status table for the fill/overflow run, a
// scoreboard queue checked on every tx_start, and a busy-flag stub.
module tb_uart_byte_fifo;

  logic       sys_clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       clear = 1'b0;
  logic       hold_busy = 1'b0;
  logic       stub_busy = 1'b0;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [4:0] count;
  logic       empty, full, overflow;

  assign tx_busy = hold_busy | stub_busy;

  uart_byte_fifo #(.DATA_W(8), .DEPTH(16), .AW(4)) dut (
    .sys_clk  (sys_clk),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .clear    (clear),
    .tx_busy  (tx_busy),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .count    (count),
    .empty    (empty),
    .full     (full),
    .overflow (overflow)
  );

  initial forever #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [7:0] data;
    bit         accept;
    logic [4:0] exp_count;
    logic       exp_full;
    logic       exp_ovf;
  } vec_t;

  vec_t       vecs[17];
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] sb[$];
  int         busy_len = 5;
  int         cyc = 0;
  int         n_starts = 0;
  int         start_cyc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input bit accept);
    rx_data  = d;
    rx_valid = 1'b1;
    if (accept) sb.push_back(d);
    step();
    rx_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((sb.size() != 0 || tx_busy || !empty) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) begin
      n_vec++;
      n_err++;
      $display("FAIL drain timeout: %0d bytes still expected after %0d cycles", sb.size(), budget);
      sb.delete();
    end
    repeat (12) step();
  endtask

  initial forever begin
    @(posedge sys_clk);
    cyc++;
  end

  // transmitter stub: busy for busy_len cycles starting the cycle after tx_start
  initial begin
    int cnt = 0;
    forever begin
      @(negedge sys_clk);
      if (cnt > 0) cnt--;
      if (tx_start && busy_len > 0) cnt = busy_len;
      stub_busy = (cnt > 0);
    end
  end

  initial begin
    bit prev = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (tx_start) begin
        n_starts++;
        start_cyc.push_back(cyc);
        if (prev) begin
          n_vec++;
          n_err++;
          $display("FAIL tx_start width: high for two cycles in a row at cycle %0d", cyc);
        end
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected tx_start: tx_data %02h, no byte expected", tx_data);
        end else begin
          check("tx_data order", {24'h0, tx_data}, {24'h0, sb.pop_front()});
        end
      end
      prev = tx_start;
    end
  end

  initial begin
    int s0;
    int n;
    int cw;

    for (int i = 0; i < 17; i++) begin
      vecs[i].data      = 8'(i);
      vecs[i].accept    = (i < 16);
      vecs[i].exp_count = (i < 16) ? 5'(i + 1) : 5'd16;
      vecs[i].exp_full  = (i >= 15);
      vecs[i].exp_ovf   = (i == 16);
    end

    repeat (3) @(posedge sys_clk);
    #1;
    check("reset count", count, 0);
    check("reset empty", empty, 1);
    check("reset full", full, 0);
    check("reset overflow", overflow, 0);
    check("reset tx_start", tx_start, 0);
    check("reset tx_data", tx_data, 0);
    reset = 1'b1;
    step();

    // single byte, idle transmitter
    busy_len = 20;
    send(8'h5A, 1'b1);
    check("t1 count after write", count, 1);
    check("t1 empty after write", empty, 0);
    step();
    step();
    check("t1 tx_start latency", tx_start, 1);
    check("t1 tx_data", tx_data, 8'h5A);
    check("t1 count after pop", count, 0);
    check("t1 empty after pop", empty, 1);
    step();
    check("t1 tx_start one cycle", tx_start, 0);
    wait_drain(200);

    // paced burst
    busy_len = 100;
    hold_busy = 1'b1;
    s0 = n_starts;
    send(8'h31, 1'b1);
    send(8'h32, 1'b1);
    send(8'h33, 1'b1);
    check("t2 count after burst", count, 3);
    hold_busy = 1'b0;
    wait_drain(1000);
    check("t2 start pulses", n_starts - s0, 3);

    // fill past full with transmitter held busy
    busy_len = 5;
    hold_busy = 1'b1;
    for (int i = 0; i < 17; i++) begin
      send(vecs[i].data, vecs[i].accept);
      check($sformatf("t3 count[%0d]", i), count, vecs[i].exp_count);
      check($sformatf("t3 full[%0d]", i), full, vecs[i].exp_full);
      check($sformatf("t3 overflow[%0d]", i), overflow, vecs[i].exp_ovf);
      check($sformatf("t3 empty[%0d]", i), empty, 0);
    end
    hold_busy = 1'b0;
    wait_drain(500);
    check("t3 overflow sticky", overflow, 1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("t3 overflow cleared", overflow, 0);

    // full FIFO, write lands in the LOAD cycle
    hold_busy = 1'b1;
    for (int i = 0; i < 16; i++) send(8'(8'h40 + i), 1'b1);
    check("t4 full before", full, 1);
    check("t4 count before", count, 16);
    hold_busy = 1'b0;
    step();
    send(8'hAA, 1'b1);
    check("t4 count after write+pop", count, 16);
    check("t4 overflow after write+pop", overflow, 0);
    check("t4 full after write+pop", full, 1);
    wait_drain(500);

    // 40 bytes with stalls, pointers wrap
    busy_len = 3;
    s0 = n_starts;
    for (int i = 0; i < 40; i++) begin
      send(8'(8'h80 + i), 1'b1);
      if (i % 13 == 12) begin
        hold_busy = 1'b1;
        repeat (20) step();
        hold_busy = 1'b0;
      end else begin
        repeat ($urandom_range(8, 14)) step();
      end
    end
    wait_drain(800);
    check("t5 start pulses", n_starts - s0, 40);

    // clear with bytes queued; rx_valid alongside clear is dropped
    hold_busy = 1'b1;
    for (int i = 0; i < 5; i++) send(8'(8'hD0 + i), 1'b1);
    check("t6 count queued", count, 5);
    rx_data  = 8'hEE;
    rx_valid = 1'b1;
    clear    = 1'b1;
    step();
    clear    = 1'b0;
    rx_valid = 1'b0;
    sb.delete();
    check("t6 count after clear", count, 0);
    check("t6 empty after clear", empty, 1);
    check("t6 overflow after clear", overflow, 0);
    s0 = n_starts;
    hold_busy = 1'b0;
    repeat (20) step();
    check("t6 no start after clear", n_starts - s0, 0);

    // reset while the transmitter is busy with a frame
    busy_len = 30;
    send(8'h61, 1'b1);
    send(8'h62, 1'b1);
    n = 0;
    while (!tx_start && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) begin
      n_vec++;
      n_err++;
      $display("FAIL t7 first start: no tx_start within %0d cycles", n);
    end
    repeat (4) step();
    reset = 1'b0;
    #1;
    check("t7 reset count", count, 0);
    check("t7 reset empty", empty, 1);
    check("t7 reset full", full, 0);
    check("t7 reset tx_start", tx_start, 0);
    check("t7 reset tx_data", tx_data, 0);
    check("t7 reset overflow", overflow, 0);
    sb.delete();
    s0 = n_starts;
    repeat (3) step();
    reset = 1'b1;
    repeat (60) step();
    check("t7 no start after reset", n_starts - s0, 0);

    // WAIT_HI timeout: transmitter never goes busy
    busy_len = 0;
    send(8'hC1, 1'b1);
    cw = cyc;
    send(8'hC2, 1'b1);
    wait_drain(100);
    if (start_cyc.size() >= 2) begin
      check("t8 first start latency", start_cyc[start_cyc.size()-2] - cw, 2);
      check("t8 timeout restart gap",
            start_cyc[start_cyc.size()-1] - start_cyc[start_cyc.size()-2], 7);
    end else begin
      n_vec++;
      n_err++;
      $display("FAIL t8 starts: got %0d recorded, expected at least 2", start_cyc.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
